sht21_iic_responder: RTL and testbench

IIC target (slave) model of the SHT21 humidity/temperature sensor: it answers the two-phase "write command, then read result" transaction issued by the team's IIC master controller. It returns a 16-bit measurement followed by its CRC-8 checksum. It can hold SCL low during the measurement, as the sensor does in hold-master mode. It sits in the simulation/loopback environment on the same open-drain bus as the master controller, and can also be synthesized to provide an on-FPGA sensor stand-in.

---
 rtl/sht21_iic_responder_if.sv | 23 ++
 rtl/sht21_iic_responder.sv | 202 ++++++++++++++++++++
 tb/tb_sht21_iic_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sht21_iic_responder_if.sv
// Open-drain IIC bus view plus sensor data/status signals of the SHT21 responder.
// Pure wiring: no storage, zero latency.
// No backpressure: the bus is clocked by the master; the responder can only stretch SCL.
interface sht21_iic_responder_if;
  logic        scl_in;
  logic        sda_in;
  logic        scl_oe;
  logic        sda_oe;
  logic [15:0] tem_data;
  logic [15:0] hum_data;
  logic [7:0]  cmd_last;
  logic        meas_done;

  modport slave (
    input  scl_in, sda_in, tem_data, hum_data,
    output scl_oe, sda_oe, cmd_last, meas_done
  );

  modport master (
    output scl_in, sda_in, tem_data, hum_data,
    input  scl_oe, sda_oe, cmd_last, meas_done
  );
endinterface

// File: rtl/sht21_iic_responder.sv
// SHT21 IIC target model: accepts a measure command, returns MSB, LSB and CRC-8 on the read phase.
// START/STOP act 3 clks after the bus edge; sda_oe moves 3 clks after a raw SCL fall.
// Backpressure: holds SCL low for HOLD_CYCLES clks before the first read byte.
module sht21_iic_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h40,
  parameter logic [7:0]  CMD_T       = 8'hE3,
  parameter logic [7:0]  CMD_H       = 8'hE5,
  parameter logic [15:0] HOLD_CYCLES = 16'd1000
) (
  input  logic                 clk,
  input  logic                 rst,
  sht21_iic_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CMD, S_WAIT_RS, S_HOLD, S_TX, S_IGNORE
  } state_t;

  localparam logic [7:0] ADDR_WR = {DEV_ADDR, 1'b0};
  localparam logic [7:0] ADDR_RD = {DEV_ADDR, 1'b1};

  // Bitwise CRC-8, poly 0x31, init 0x00, MSB first, no reflection.
  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h31;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  logic [1:0]  r_scl_sync, r_sda_sync;
  logic        r_scl_prev, r_sda_prev;
  state_t      r_state;
  logic        r_sda_oe, r_scl_oe, r_meas_done, r_pending;
  logic [7:0]  r_cmd_last, r_shift;
  logic [3:0]  r_bit_cnt;
  logic [1:0]  r_byte_idx;
  logic [15:0] r_word, r_hold_cnt;

  logic        w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [15:0] w_resp_word;
  logic [7:0]  w_crc, w_tx_byte, w_next_byte;

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

  assign w_resp_word = (r_cmd_last == CMD_T) ? bus.tem_data : bus.hum_data;
  assign w_crc       = crc8(r_word);

  // Byte currently being shifted out, and the one that follows it after an ACK.
  always_comb begin
    w_tx_byte   = r_word[15:8];
    w_next_byte = r_word[7:0];
    case (r_byte_idx)
      2'd0:    begin w_tx_byte = r_word[15:8]; w_next_byte = r_word[7:0]; end
      2'd1:    begin w_tx_byte = r_word[7:0];  w_next_byte = w_crc;       end
      default: begin w_tx_byte = w_crc;        w_next_byte = w_crc;       end
    endcase
  end

  assign bus.scl_oe    = r_scl_oe;
  assign bus.sda_oe    = r_sda_oe;
  assign bus.cmd_last  = r_cmd_last;
  assign bus.meas_done = r_meas_done;

  // Two-flop synchronizers plus one-clk history for edge and START/STOP detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], bus.scl_in};
      r_sda_sync <= {r_sda_sync[0], bus.sda_in};
      r_scl_prev <= r_scl_sync[1];
      r_sda_prev <= r_sda_sync[1];
    end
  end

  // Protocol FSM; START/STOP override any SCL edge seen in the same clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sda_oe    <= 1'b0;
      r_scl_oe    <= 1'b0;
      r_meas_done <= 1'b0;
      r_pending   <= 1'b0;
      r_cmd_last  <= 8'h00;
      r_shift     <= 8'h00;
      r_bit_cnt   <= 4'd0;
      r_byte_idx  <= 2'd0;
      r_word      <= 16'h0000;
      r_hold_cnt  <= 16'd0;
    end else begin
      r_meas_done <= 1'b0;
      if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_scl_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_scl_oe <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_CMD: begin
            if (w_scl_rise && r_bit_cnt != 4'd9) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt < 4'd8) r_shift <= {r_shift[6:0], w_sda};
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              // Full byte in: ACK by pulling SDA, or leave SDA released and ignore the rest.
              if (r_state == S_ADDR) begin
                if (r_shift == ADDR_WR || (r_shift == ADDR_RD && r_pending)) r_sda_oe <= 1'b1;
                else r_state <= S_IGNORE;
              end else begin
                if (r_shift == CMD_T || r_shift == CMD_H) begin
                  r_sda_oe   <= 1'b1;
                  r_cmd_last <= r_shift;
                  r_pending  <= 1'b1;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
            end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
              // End of our ACK bit.
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 4'd0;
              if (r_state == S_CMD) begin
                r_state <= S_WAIT_RS;
              end else if (r_shift == ADDR_WR) begin
                r_state <= S_CMD;
              end else begin
                r_word     <= w_resp_word;
                r_byte_idx <= 2'd0;
                r_hold_cnt <= 16'd0;
                if (HOLD_CYCLES == 16'd0) begin
                  r_state  <= S_TX;
                  r_sda_oe <= ~w_resp_word[15];
                end else begin
                  r_state  <= S_HOLD;
                  r_scl_oe <= 1'b1;
                end
              end
            end
          end
          S_HOLD: begin
            // Release SCL and present the first data bit in the same clk.
            if (r_hold_cnt == HOLD_CYCLES - 16'd1) begin
              r_scl_oe <= 1'b0;
              r_sda_oe <= ~r_word[15];
              r_state  <= S_TX;
            end else begin
              r_hold_cnt <= r_hold_cnt + 16'd1;
            end
          end
          S_TX: begin
            if (w_scl_rise) begin
              if (r_bit_cnt == 4'd8) begin
                // Master ACK/NACK sample; the CRC byte ends the measurement either way.
                if (r_byte_idx == 2'd2) begin
                  r_meas_done <= 1'b1;
                  r_pending   <= 1'b0;
                  r_state     <= S_IGNORE;
                end else if (w_sda) begin
                  r_state <= S_IGNORE;
                end else begin
                  r_bit_cnt <= 4'd9;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end else if (w_scl_fall) begin
              if (r_bit_cnt < 4'd8) begin
                r_sda_oe <= ~w_tx_byte[3'd7 - r_bit_cnt[2:0]];
              end else if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
              end else begin
                r_byte_idx <= r_byte_idx + 2'd1;
                r_bit_cnt  <= 4'd0;
                r_sda_oe   <= ~w_next_byte[7];
              end
            end
          end
          S_IGNORE: begin
            r_sda_oe <= 1'b0;
            r_scl_oe <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sht21_iic_responder.sv
// Bench for sht21_iic_responder: bit-banged IIC master on an open-drain bus model.
// Table of read transactions plus hand-written abort/reset/error sequences.
// Read bytes are checked against a queue of expected bytes pushed before each read.
module tb_sht21_iic_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] tem_v = 16'h0000;
  logic [15:0] hum_v = 16'h0000;

  sht21_iic_responder_if bus();

  sht21_iic_responder dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  assign bus.scl_in   = scl_m & ~bus.scl_oe;
  assign bus.sda_in   = sda_m & ~bus.sda_oe;
  assign bus.tem_data = tem_v;
  assign bus.hum_data = hum_v;

  int n_vec = 0;
  int n_err = 0;
  int run_len = 0, last_run = 0, md_cnt = 0, sda_drv = 0;
  bit watch_sda = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] tem;
    logic [15:0] hum;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [7:0]  e2;
  } vec_t;
  vec_t vt[4];

  // Bus monitors: SCL stretch run length, meas_done pulses, unexpected SDA drive.
  always @(negedge clk) begin
    if (bus.scl_oe) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (bus.meas_done) md_cnt++;
    if (watch_sda && bus.sda_oe) sda_drv++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at time limit, expected summary");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic scl_up();
    int w;
    scl_m = 1'b1;
    w = 0;
    while (bus.scl_in !== 1'b1 && w < 5000) begin
      tick(1);
      w++;
    end
    if (w >= 5000) begin
      n_vec++;
      n_err++;
      $display("FAIL scl_release: SCL low for %0d clks, expected release", w);
    end
  endtask

  task automatic start_c();
    sda_m = 1'b1; tick(3); scl_up(); tick(5);
    sda_m = 1'b0; tick(5); scl_m = 1'b0; tick(5);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; tick(3); scl_up(); tick(5);
    sda_m = 1'b1; tick(5);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(5); scl_up(); tick(10); scl_m = 1'b0; tick(5);
    end
    sda_m = 1'b1; tick(5); scl_up(); tick(5);
    ack = ~bus.sda_in;
    tick(5); scl_m = 1'b0; tick(5);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(5); scl_up(); tick(5);
      b[i] = bus.sda_in;
      tick(5); scl_m = 1'b0; tick(5);
    end
    sda_m = ~mack; tick(5); scl_up(); tick(10); scl_m = 1'b0; tick(5);
  endtask

  task automatic rd3(input string tag);
    logic [7:0] rb;
    for (int k = 0; k < 3; k++) begin
      rd_byte(k < 2, rb);
      chk($sformatf("%s byte%0d", tag, k), rb, exp_q.pop_front());
    end
  endtask

  task automatic run_read(input vec_t v, input string tag);
    logic a;
    int   md0;
    tem_v = v.tem;
    hum_v = v.hum;
    md0   = md_cnt;
    start_c();
    wr_byte(8'h80, a); chk($sformatf("%s addr_w_ack", tag), a, 1);
    wr_byte(v.cmd, a); chk($sformatf("%s cmd_ack", tag), a, 1);
    start_c();
    wr_byte(8'h81, a); chk($sformatf("%s addr_r_ack", tag), a, 1);
    exp_q.push_back(v.e0);
    exp_q.push_back(v.e1);
    exp_q.push_back(v.e2);
    rd3(tag);
    stop_c(); tick(2);
    chk($sformatf("%s stretch_clks", tag), last_run, 1000);
    chk($sformatf("%s meas_done_pulses", tag), md_cnt - md0, 1);
    chk($sformatf("%s cmd_last", tag), bus.cmd_last, v.cmd);
  endtask

  initial begin
    logic       a;
    logic [7:0] rb;
    int         md0;

    vt[0] = '{8'hE3, 16'h4E85, 16'h683A, 8'h4E, 8'h85, 8'h6B};
    vt[1] = '{8'hE5, 16'h4E85, 16'h683A, 8'h68, 8'h3A, 8'h7C};
    vt[2] = '{8'hE3, 16'h0000, 16'h683A, 8'h00, 8'h00, 8'h00};
    vt[3] = '{8'hE5, 16'h683A, 16'h4E85, 8'h4E, 8'h85, 8'h6B};

    // Reset state
    tick(3);
    chk("rst scl_oe", bus.scl_oe, 0);
    chk("rst sda_oe", bus.sda_oe, 0);
    chk("rst cmd_last", bus.cmd_last, 8'h00);
    chk("rst meas_done", bus.meas_done, 0);
    rst = 1'b0;
    tick(5);

    for (int i = 0; i < 4; i++) run_read(vt[i], $sformatf("vec%0d", i));

    // Wrong address: NACK, then SDA left alone for the rest of the transfer
    start_c();
    wr_byte(8'h82, a); chk("bad_addr ack", a, 0);
    watch_sda = 1'b1;
    wr_byte(8'h00, a); chk("bad_addr data ack", a, 0);
    stop_c();
    watch_sda = 1'b0;
    chk("bad_addr sda_driven_clks", sda_drv, 0);
    run_read(vt[0], "after_bad_addr");

    // Bad command, then read with nothing pending
    start_c();
    wr_byte(8'h80, a); chk("bad_cmd addr_ack", a, 1);
    wr_byte(8'hF3, a); chk("bad_cmd cmd_ack", a, 0);
    chk("bad_cmd cmd_last", bus.cmd_last, 8'hE3);
    stop_c();
    start_c();
    wr_byte(8'h81, a); chk("no_pending read_ack", a, 0);
    stop_c();

    // Master NACKs the MSB: no meas_done, command stays pending for a later read
    md0 = md_cnt;
    tem_v = 16'h4E85;
    start_c();
    wr_byte(8'h80, a); wr_byte(8'hE3, a);
    start_c();
    wr_byte(8'h81, a); chk("nack_msb addr_r_ack", a, 1);
    rd_byte(1'b0, rb); chk("nack_msb byte0", rb, 8'h4E);
    tick(4);
    chk("nack_msb sda_oe", bus.sda_oe, 0);
    stop_c(); tick(4);
    chk("nack_msb idle sda_oe", bus.sda_oe, 0);
    chk("nack_msb idle scl_oe", bus.scl_oe, 0);
    chk("nack_msb meas_done_pulses", md_cnt - md0, 0);
    start_c();
    wr_byte(8'h81, a); chk("still_pending addr_r_ack", a, 1);
    exp_q.push_back(8'h4E);
    exp_q.push_back(8'h85);
    exp_q.push_back(8'h6B);
    rd3("still_pending");
    stop_c(); tick(2);
    chk("still_pending meas_done_pulses", md_cnt - md0, 1);

    // Reset during the SCL stretch releases SCL without a clock edge
    hum_v = 16'h683A;
    start_c();
    wr_byte(8'h80, a); wr_byte(8'hE5, a);
    start_c();
    wr_byte(8'h81, a);
    tick(20);
    chk("hold scl_oe", bus.scl_oe, 1);
    rst = 1'b1;
    #1;
    chk("hold_rst scl_oe", bus.scl_oe, 0);
    tick(2);
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    tick(5);

    // Reset mid-LSB byte while the responder pulls SDA low
    start_c();
    wr_byte(8'h80, a); wr_byte(8'hE5, a);
    start_c();
    wr_byte(8'h81, a);
    rd_byte(1'b1, rb); chk("mid_lsb byte0", rb, 8'h68);
    sda_m = 1'b1; tick(5); scl_up(); tick(5);
    chk("mid_lsb bit7", bus.sda_in, 0);
    tick(5); scl_m = 1'b0; tick(5);
    chk("mid_lsb sda_oe before rst", bus.sda_oe, 1);
    rst = 1'b1;
    #1;
    chk("mid_lsb_rst sda_oe", bus.sda_oe, 0);
    chk("mid_lsb_rst scl_oe", bus.scl_oe, 0);
    tick(2);
    chk("mid_lsb_rst cmd_last", bus.cmd_last, 8'h00);
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    tick(5);
    start_c();
    wr_byte(8'h81, a); chk("post_rst read_ack", a, 0);
    stop_c();
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
